barrelshifter_pipe: RTL and testbench

BARRELSHIFTER_PIPE -- requirements
Module: barrelshifter_pipe

---
 rtl/barrelshifter_pkg.sv | 23 ++
 rtl/barrelshifter_stage.sv | 69 ++++++
 rtl/barrelshifter_pipe.sv | 162 ++++++++++++++++
 tb/tb_barrelshifter_pipe.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrelshifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   - SHIFT_OP encodings (LSL/LSR/ASR/ROR/RRX; remaining codes pass through)
//   - width_legal(): legal WIDTH values
//   - stage_lo(): first mux level owned by a pipeline stage
package barrelshifter_pkg;

  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ASR = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_RRX = 3'b100;

  function automatic bit width_legal(int w);
    return (w == 8) || (w == 16) || (w == 32) || (w == 64);
  endfunction

  // Spreads `levels` mux levels over `stages` registers as evenly as possible;
  // stage s owns levels [stage_lo(s), stage_lo(s+1)).
  function automatic int stage_lo(int levels, int stages, int s);
    return (s * levels) / stages;
  endfunction

endpackage

// File: rtl/barrelshifter_stage.sv
// One pipeline stage of the barrel shifter: a group of right-shift mux levels
// [LO, HI) followed by a register.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : advance the pipeline (low while the output is stalled)
//   flush       : clear the valid bit regardless of en
//   valid/vec/amt/op            : incoming beat
//   stage_valid/stage_vec/stage_amt/stage_op : registered beat
// vec is {fill, data, carry}: bit 0 holds the incoming Carry_flag and after
// shifting holds the partial carry (last bit shifted out).
module barrelshifter_stage #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5,
  parameter int LO    = 0,
  parameter int HI    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 valid,
  input  logic [2*WIDTH-1:0]   vec,
  input  logic [AMT_W-1:0]     amt,
  input  logic [2:0]           op,
  output logic                 stage_valid,
  output logic [2*WIDTH-1:0]   stage_vec,
  output logic [AMT_W-1:0]     stage_amt,
  output logic [2:0]           stage_op
);

  localparam int NLV = HI - LO;

  logic [2*WIDTH-1:0] lvl [NLV+1];
  logic               valid_reg;
  logic [2*WIDTH-1:0] vec_reg;
  logic [AMT_W-1:0]   amt_reg;
  logic [2:0]         op_reg;

  assign lvl[0] = vec;

  for (genvar gi = 0; gi < NLV; gi++) begin : g_level
    assign lvl[gi+1] = amt[LO+gi] ? (lvl[gi] >> (2 ** (LO + gi))) : lvl[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      vec_reg   <= '0;
      amt_reg   <= '0;
      op_reg    <= '0;
    end else begin
      if (flush) begin
        valid_reg <= 1'b0;
      end else if (en) begin
        valid_reg <= valid;
      end
      if (en) begin
        vec_reg <= lvl[NLV];
        amt_reg <= amt;
        op_reg  <= op;
      end
    end
  end

  assign stage_valid = valid_reg;
  assign stage_vec   = vec_reg;
  assign stage_amt   = amt_reg;
  assign stage_op    = op_reg;

endmodule

// File: rtl/barrelshifter_pipe.sv
// Pipelined ARM-style barrel shifter with valid/ready handshake.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready          : operand handshake
//   Shift_Data, Shift_Num      : data and unsigned shift amount
//   Carry_flag, SHIFT_OP       : incoming carry and shift mode
//   flush                      : discard every in-flight beat
//   out_valid/out_ready        : result handshake
//   Shift_out, Shift_carry_out : result data and carry
// Every mode is mapped onto one right-shift engine working on
// {fill, data, carry}: LSL works on bit-reversed data, ASR fills with the sign,
// ROR fills with the data itself, RRX is a shift by one with Carry_flag as
// fill. Amounts >= WIDTH are resolved up front so the engine needs only
// log2(WIDTH) levels.
module barrelshifter_pipe
  import barrelshifter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_W  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Shift_Data,
  input  logic [NUM_W-1:0] Shift_Num,
  input  logic             Carry_flag,
  input  logic [2:0]       SHIFT_OP,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Shift_out,
  output logic             Shift_carry_out
);

  localparam int LW = $clog2(WIDTH);
  localparam int VW = 2 * WIDTH;

  if (!width_legal(WIDTH) || NUM_W < LW + 1 || STAGES < 1 || STAGES > 3) begin : g_bad_params
    $error("barrelshifter_pipe: illegal WIDTH/NUM_W/STAGES");
  end

  logic             v_valid [STAGES+1];
  logic [VW-1:0]    v_vec   [STAGES+1];
  logic [LW-1:0]    v_amt   [STAGES+1];
  logic [2:0]       v_op    [STAGES+1];

  logic [WIDTH-1:0] d_rev;
  logic [WIDTH-1:0] body;
  logic [WIDTH-2:0] fill;
  logic             cin;
  logic [LW-1:0]    k;
  logic             big;
  logic             at_w;
  logic             n_zero;
  logic             sign;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_in_rev
    assign d_rev[gi] = Shift_Data[WIDTH-1-gi];
  end

  assign big    = Shift_Num >= NUM_W'(WIDTH);
  assign at_w   = Shift_Num == NUM_W'(WIDTH);
  assign n_zero = Shift_Num == '0;
  assign sign   = Shift_Data[WIDTH-1];

  always_comb begin
    fill = '0;
    body = Shift_Data;
    cin  = Carry_flag;
    k    = '0;
    case (SHIFT_OP)
      OP_LSL: begin
        body = d_rev;
        k    = Shift_Num[LW-1:0];
        if (big) begin
          body = '0;
          k    = '0;
          cin  = at_w & Shift_Data[0];
        end
      end
      OP_LSR: begin
        k = Shift_Num[LW-1:0];
        if (big) begin
          body = '0;
          k    = '0;
          cin  = at_w & sign;
        end
      end
      OP_ASR: begin
        fill = {(WIDTH-1){sign}};
        k    = Shift_Num[LW-1:0];
        if (big) begin
          body = {WIDTH{sign}};
          k    = '0;
          cin  = sign;
        end
      end
      OP_ROR: begin
        // A rotate by a non-zero multiple of WIDTH leaves k = 0, so the
        // carry slot must already hold data[W-1].
        fill = Shift_Data[WIDTH-2:0];
        k    = Shift_Num[LW-1:0];
        if (!n_zero) begin
          cin = sign;
        end
      end
      OP_RRX: begin
        fill[0] = Carry_flag;
        k       = LW'(1);
      end
      default: ;
    endcase
  end

  assign in_ready   = !out_valid || out_ready;
  assign v_valid[0] = in_valid;
  assign v_vec[0]   = {fill, body, cin};
  assign v_amt[0]   = k;
  assign v_op[0]    = SHIFT_OP;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    barrelshifter_stage #(
      .WIDTH (WIDTH),
      .AMT_W (LW),
      .LO    (stage_lo(LW, STAGES, gi)),
      .HI    (stage_lo(LW, STAGES, gi + 1))
    ) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (in_ready),
      .flush       (flush),
      .valid       (v_valid[gi]),
      .vec         (v_vec[gi]),
      .amt         (v_amt[gi]),
      .op          (v_op[gi]),
      .stage_valid (v_valid[gi+1]),
      .stage_vec   (v_vec[gi+1]),
      .stage_amt   (v_amt[gi+1]),
      .stage_op    (v_op[gi+1])
    );
  end

  // Result window sits just above the carry bit; LSL undoes the input reversal.
  logic [WIDTH-1:0] window;
  logic [WIDTH-1:0] window_rev;

  assign window = v_vec[STAGES][WIDTH:1];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out_rev
    assign window_rev[gi] = window[WIDTH-1-gi];
  end

  assign out_valid       = v_valid[STAGES];
  assign Shift_out       = (v_op[STAGES] == OP_LSL) ? window_rev : window;
  assign Shift_carry_out = v_vec[STAGES][0];

  // Fill bits and the spent amount are dead after the last level.
  logic unused_tail;
  assign unused_tail = ^{v_vec[STAGES][VW-1:WIDTH+1], v_amt[STAGES]};

endmodule

// File: tb/tb_barrelshifter_pipe.sv
module tb_barrelshifter_pipe;
  import barrelshifter_pkg::*;

  typedef struct {
    logic [63:0] d;
    logic        c;
  } res_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] d;
    logic [7:0]  n;
    logic        cf;
    logic [31:0] eo;
    logic        ec;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic        Carry_flag;
  logic [63:0] Shift_Data;
  logic [7:0]  Shift_Num;
  logic [2:0]  SHIFT_OP;

  logic        rdy8, rdy32, rdy64;
  logic        ov8, ov32, ov64;
  logic        sc8, sc32, sc64;
  logic [7:0]  so8;
  logic [31:0] so32;
  logic [63:0] so64;

  int checks = 0;
  int failures = 0;

  barrelshifter_pipe #(.WIDTH(8), .NUM_W(8), .STAGES(1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .Shift_Data(Shift_Data[7:0]), .Shift_Num(Shift_Num), .Carry_flag(Carry_flag),
    .SHIFT_OP(SHIFT_OP), .flush(flush), .out_valid(ov8), .out_ready(out_ready),
    .Shift_out(so8), .Shift_carry_out(sc8));

  barrelshifter_pipe #(.WIDTH(32), .NUM_W(8), .STAGES(2)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .Shift_Data(Shift_Data[31:0]), .Shift_Num(Shift_Num), .Carry_flag(Carry_flag),
    .SHIFT_OP(SHIFT_OP), .flush(flush), .out_valid(ov32), .out_ready(out_ready),
    .Shift_out(so32), .Shift_carry_out(sc32));

  barrelshifter_pipe #(.WIDTH(64), .NUM_W(8), .STAGES(3)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
    .Shift_Data(Shift_Data), .Shift_Num(Shift_Num), .Carry_flag(Carry_flag),
    .SHIFT_OP(SHIFT_OP), .flush(flush), .out_valid(ov64), .out_ready(out_ready),
    .Shift_out(so64), .Shift_carry_out(sc64));

  logic        i_ready [3];
  logic        o_valid [3];
  logic [63:0] o_data  [3];
  logic        o_c     [3];
  int          wd      [3];

  assign i_ready[0] = rdy8;
  assign i_ready[1] = rdy32;
  assign i_ready[2] = rdy64;
  assign o_valid[0] = ov8;
  assign o_valid[1] = ov32;
  assign o_valid[2] = ov64;
  assign o_data[0]  = {56'd0, so8};
  assign o_data[1]  = {32'd0, so32};
  assign o_data[2]  = so64;
  assign o_c[0]     = sc8;
  assign o_c[1]     = sc32;
  assign o_c[2]     = sc64;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: direct arithmetic on the shift rules, result masked to w bits.
  function automatic res_t ref_model(int w, logic [63:0] din, logic [7:0] nn, logic c, logic [2:0] op);
    res_t        r;
    logic [63:0] mask;
    logic [63:0] d;
    logic        sign;
    int          n;
    int          s;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    d    = din & mask;
    n    = int'(nn);
    sign = d[w-1];
    r.d  = d;
    r.c  = c;
    case (op)
      OP_LSL: begin
        if (n == 0) begin end
        else if (n < w) begin r.d = (d << n) & mask; r.c = d[w-n]; end
        else begin r.d = 64'd0; r.c = (n == w) ? d[0] : 1'b0; end
      end
      OP_LSR: begin
        if (n == 0) begin end
        else if (n < w) begin r.d = d >> n; r.c = d[n-1]; end
        else begin r.d = 64'd0; r.c = (n == w) ? d[w-1] : 1'b0; end
      end
      OP_ASR: begin
        if (n == 0) begin end
        else if (n < w) begin
          r.d = (d >> n) | (sign ? (mask & ~(mask >> n)) : 64'd0);
          r.c = d[n-1];
        end else begin r.d = sign ? mask : 64'd0; r.c = sign; end
      end
      OP_ROR: begin
        if (n != 0) begin
          s = n % w;
          if (s == 0) r.c = d[w-1];
          else begin r.d = ((d >> s) | (d << (w - s))) & mask; r.c = r.d[w-1]; end
        end
      end
      OP_RRX: begin
        r.d = ({63'd0, c} << (w - 1)) | (d >> 1);
        r.c = d[0];
      end
      default: ;
    endcase
    return r;
  endfunction

  // Per-instance scoreboard: push on accept, pop and compare on delivery.
  res_t exp_q [3][$];

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int m = 0; m < 3; m++) exp_q[m].delete();
    end else begin
      for (int m = 0; m < 3; m++) begin
        if (o_valid[m] && out_ready) begin
          if (exp_q[m].size() == 0) begin
            chk($sformatf("w%0d_unexpected_beat", wd[m]), 64'd1, 64'd0);
          end else begin
            res_t e;
            e = exp_q[m].pop_front();
            chk($sformatf("w%0d_stream_data", wd[m]), o_data[m], e.d);
            chk($sformatf("w%0d_stream_carry", wd[m]), {63'd0, o_c[m]}, {63'd0, e.c});
          end
        end
        if (flush) exp_q[m].delete();
        else if (in_valid && i_ready[m])
          exp_q[m].push_back(ref_model(wd[m], Shift_Data, Shift_Num, Carry_flag, SHIFT_OP));
      end
    end
  end

  vec_t tbl [13];

  initial begin
    int          sent;
    int          got;
    int          hs;
    logic [31:0] got_v [4];
    logic [31:0] hv;

    wd[0] = 8; wd[1] = 32; wd[2] = 64;
    tbl[0]  = '{OP_LSL, 32'h80000001, 8'd1,  1'b0, 32'h00000002, 1'b1};
    tbl[1]  = '{OP_LSR, 32'h80000000, 8'd32, 1'b0, 32'h00000000, 1'b1};
    tbl[2]  = '{OP_LSR, 32'hFFFFFFFF, 8'd33, 1'b1, 32'h00000000, 1'b0};
    tbl[3]  = '{OP_ASR, 32'h80000000, 8'd40, 1'b0, 32'hFFFFFFFF, 1'b1};
    tbl[4]  = '{OP_ROR, 32'h80000001, 8'd32, 1'b0, 32'h80000001, 1'b1};
    tbl[5]  = '{OP_RRX, 32'h00000003, 8'd7,  1'b1, 32'h80000001, 1'b1};
    tbl[6]  = '{OP_LSL, 32'h12345678, 8'd0,  1'b1, 32'h12345678, 1'b1};
    tbl[7]  = '{OP_LSR, 32'h000000F8, 8'd4,  1'b0, 32'h0000000F, 1'b1};
    tbl[8]  = '{OP_ROR, 32'h0000000F, 8'd4,  1'b0, 32'hF0000000, 1'b1};
    tbl[9]  = '{3'b101, 32'hA5A5A5A5, 8'd3,  1'b1, 32'hA5A5A5A5, 1'b1};
    tbl[10] = '{OP_LSL, 32'h00000001, 8'd32, 1'b0, 32'h00000000, 1'b1};
    tbl[11] = '{OP_ASR, 32'h80000010, 8'd4,  1'b1, 32'hF8000001, 1'b0};
    tbl[12] = '{OP_LSL, 32'hFFFFFFFF, 8'd35, 1'b1, 32'h00000000, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    Carry_flag = 1'b0; Shift_Data = '0; Shift_Num = '0; SHIFT_OP = OP_LSL;
    repeat (2) tick();
    chk("reset_out_valid", {63'd0, ov32}, 64'd0);
    chk("reset_shift_out", {32'd0, so32}, 64'd0);
    chk("reset_carry", {63'd0, sc32}, 64'd0);
    chk("reset_in_ready", {63'd0, rdy32}, 64'd1);
    rst_n = 1'b1;

    // Directed vectors, one at a time, latency checked on each.
    for (int i = 0; i < 13; i++) begin
      SHIFT_OP = tbl[i].op; Shift_Data = {32'd0, tbl[i].d};
      Shift_Num = tbl[i].n; Carry_flag = tbl[i].cf; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid_early", i), {63'd0, ov32}, 64'd0);
      tick();
      chk($sformatf("vec%0d_valid", i), {63'd0, ov32}, 64'd1);
      chk($sformatf("vec%0d_data", i), {32'd0, so32}, {32'd0, tbl[i].eo});
      chk($sformatf("vec%0d_carry", i), {63'd0, sc32}, {63'd0, tbl[i].ec});
    end
    tick();

    // Four back-to-back beats, consumer stalls during cycles 3..5.
    sent = 0; got = 0;
    for (int c = 1; c <= 14; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid = (sent < 4);
      SHIFT_OP = OP_LSL; Shift_Data = 64'd1; Carry_flag = 1'b0; Shift_Num = 8'(sent);
      #1;
      if (c >= 3 && c <= 5) begin
        chk($sformatf("stall_c%0d_in_ready", c), {63'd0, rdy32}, 64'd0);
        chk($sformatf("stall_c%0d_valid", c), {63'd0, ov32}, 64'd1);
        chk($sformatf("stall_c%0d_hold", c), {32'd0, so32}, 64'd1);
      end
      if (in_valid && rdy32) sent++;
      if (ov32 && out_ready) begin
        if (got < 4) got_v[got] = so32;
        got++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("stall_delivered", 64'(got), 64'd4);
    for (int b = 0; b < 4; b++) chk($sformatf("stall_order%0d", b), {32'd0, got_v[b]}, 64'd1 << b);

    // Flush with two beats in flight and a third presented alongside it.
    out_ready = 1'b0;
    SHIFT_OP = OP_ROR; Shift_Data = 64'h12345678; Shift_Num = 8'd8; in_valid = 1'b1;
    tick();
    SHIFT_OP = OP_LSR; Shift_Num = 8'd4;
    tick();
    SHIFT_OP = OP_ASR; Shift_Num = 8'd2; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {63'd0, ov32}, 64'd0);
    out_ready = 1'b1;
    SHIFT_OP = OP_LSL; Shift_Data = 64'h0000ABCD; Shift_Num = 8'd4; Carry_flag = 1'b0; in_valid = 1'b1;
    #1;
    chk("flush_next_ready", {63'd0, rdy32}, 64'd1);
    tick();
    in_valid = 1'b0;
    hs = 0; hv = '0;
    for (int c = 0; c < 6; c++) begin
      if (ov32 && out_ready) begin hs++; hv = so32; end
      tick();
    end
    chk("flush_handshakes", 64'(hs), 64'd1);
    chk("flush_next_data", {32'd0, hv}, 64'h000ABCD0);

    // Asynchronous reset mid-stream.
    for (int c = 0; c < 3; c++) begin
      SHIFT_OP = OP_LSR; Shift_Data = {$urandom, $urandom}; Shift_Num = 8'(c + 1); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("prerst_valid", {63'd0, ov32}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, ov32}, 64'd0);
    chk("rst_shift_out", {32'd0, so32}, 64'd0);
    chk("rst_carry", {63'd0, sc32}, 64'd0);
    chk("rst_in_ready", {63'd0, rdy32}, 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    SHIFT_OP = OP_ASR; Shift_Data = 64'h80000002; Shift_Num = 8'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("postrst_no_stale", {63'd0, ov32}, 64'd0);
    tick();
    chk("postrst_valid", {63'd0, ov32}, 64'd1);
    chk("postrst_data", {32'd0, so32}, 64'hC0000001);
    chk("postrst_carry", {63'd0, sc32}, 64'd0);
    tick();

    // Random sweep on all three widths/depths against the scoreboards.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 49) == 0);
      Shift_Data = {$urandom, $urandom};
      Shift_Num  = ($urandom_range(0, 7) < 6) ? 8'($urandom_range(0, 70)) : 8'($urandom_range(0, 255));
      Carry_flag = 1'($urandom_range(0, 1));
      SHIFT_OP   = 3'($urandom_range(0, 7));
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    for (int m = 0; m < 3; m++)
      chk($sformatf("w%0d_drained", wd[m]), 64'(exp_q[m].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
